// File: rtl/scurve_pkg.sv
// Shared definitions for the S-curve result path: frame delimiters,
// default channel word count and the frame reader state encoding.
package scurve_pkg;

    // Data words produced per channel by the S-curve channel test (1..8).
    localparam int          DEF_WORDS_PER_CHANNEL = 6;
    localparam int          MAX_WORDS_PER_CHANNEL = 8;

    localparam logic [15:0] DEF_FRAME_HEADER      = 16'hFF45;
    localparam logic [15:0] DEF_FRAME_TRAILER     = 16'hFF5A;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_WAIT    = 3'd1,
        ST_RD_PULSE   = 3'd2,
        ST_RD_CAPTURE = 3'd3,
        ST_SEND       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Channel/DAC info word that follows the header.
    function automatic logic [15:0] info_word(input logic [5:0] ch, input logic [9:0] dac);
        return {ch, dac};
    endfunction

endpackage

// File: rtl/scurve_frame_reader_if.sv
// Bus bundle between the S-curve data FIFO read port, the frame reader and
// the USB transmit FIFO write port.
//
// Handshake semantics:
//   FIFO side : the reader raises Fifo_Rd_En for exactly one cycle, only when
//               Fifo_Empty was low in the deciding cycle; Fifo_Dout is valid
//               the cycle after Fifo_Rd_En (standard, non first-word-fall-through).
//   USB side  : every cycle with Usb_Data_Wr_En high transfers Usb_Data once.
//               The reader samples Usb_Fifo_Full in the cycle it registers a
//               write decision and never registers a write while it is high.
interface scurve_frame_reader_if;
    logic        Fifo_Empty;
    logic [15:0] Fifo_Dout;
    logic        Fifo_Rd_En;
    logic        Usb_Fifo_Full;
    logic [15:0] Usb_Data;
    logic        Usb_Data_Wr_En;

    modport master (
        input  Fifo_Empty, Fifo_Dout, Usb_Fifo_Full,
        output Fifo_Rd_En, Usb_Data, Usb_Data_Wr_En
    );

    modport slave (
        output Fifo_Empty, Fifo_Dout, Usb_Fifo_Full,
        input  Fifo_Rd_En, Usb_Data, Usb_Data_Wr_En
    );
endinterface

// File: rtl/scurve_frame_reader.sv
// Drains one channel's S-curve count words from the data FIFO and frames them
// for the USB FIFO as: header, info, data words, XOR checksum, trailer.
module scurve_frame_reader
    import scurve_pkg::*;
#(
    parameter int          WORDS_PER_CHANNEL = DEF_WORDS_PER_CHANNEL,
    parameter logic [15:0] FRAME_HEADER      = DEF_FRAME_HEADER,
    parameter logic [15:0] FRAME_TRAILER     = DEF_FRAME_TRAILER
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  Packer_Enable,
    input  logic [5:0]            Channel_Index,
    input  logic [9:0]            Dac_Code,
    scurve_frame_reader_if.master bus,
    output logic                  Frame_Done,
    output logic [15:0]           Frame_Count,
    output state_t                Fsm_State
);

    // Send index layout: 0 header, 1 info, 2..N+1 data, N+2 checksum, N+3 trailer.
    localparam logic [3:0] LAST_CNT      = 4'(WORDS_PER_CHANNEL - 1);
    localparam logic [3:0] LAST_DATA_IDX = 4'(WORDS_PER_CHANNEL + 1);
    localparam logic [3:0] CSUM_IDX      = 4'(WORDS_PER_CHANNEL + 2);
    localparam logic [3:0] TRAILER_IDX   = 4'(WORDS_PER_CHANNEL + 3);

    state_t      state_q, state_d;
    logic [3:0]  word_cnt;
    logic [3:0]  send_idx;
    logic [15:0] buffer [MAX_WORDS_PER_CHANNEL];
    logic [15:0] checksum;
    logic [15:0] info_q;
    logic [15:0] send_word;

    logic        rd_en_d;
    logic        wr_en_d;
    logic        done_d;
    logic [15:0] usb_data_d;
    logic [15:0] frame_count_nxt;

    // A channel with no words captured yet may be abandoned when the enable drops.
    logic        abandon;
    assign abandon   = (word_cnt == 4'd0) && !Packer_Enable;
    assign Fsm_State = state_q;

    // State register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; once the first word is captured the frame always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (Packer_Enable) state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (abandon)              state_d = ST_IDLE;
                else if (!bus.Fifo_Empty) state_d = ST_RD_PULSE;
            end
            ST_RD_PULSE:   state_d = ST_RD_CAPTURE;
            ST_RD_CAPTURE: state_d = (word_cnt == LAST_CNT) ? ST_SEND : ST_RD_WAIT;
            ST_SEND:       if (!bus.Usb_Fifo_Full && send_idx == TRAILER_IDX) state_d = ST_DONE;
            ST_DONE:       state_d = Packer_Enable ? ST_RD_WAIT : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes, data and frame counter.
    always_comb begin
        rd_en_d         = 1'b0;
        wr_en_d         = 1'b0;
        done_d          = 1'b0;
        usb_data_d      = bus.Usb_Data;
        frame_count_nxt = Frame_Count;
        case (state_q)
            ST_RD_WAIT: rd_en_d = !abandon && !bus.Fifo_Empty;
            ST_SEND: begin
                if (!bus.Usb_Fifo_Full) begin
                    wr_en_d    = 1'b1;
                    usb_data_d = send_word;
                end
            end
            ST_DONE: begin
                done_d          = 1'b1;
                frame_count_nxt = Frame_Count + 16'd1;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.Fifo_Rd_En     <= 1'b0;
            bus.Usb_Data_Wr_En <= 1'b0;
            bus.Usb_Data       <= '0;
            Frame_Done         <= 1'b0;
            Frame_Count        <= '0;
        end else begin
            bus.Fifo_Rd_En     <= rd_en_d;
            bus.Usb_Data_Wr_En <= wr_en_d;
            bus.Usb_Data       <= usb_data_d;
            Frame_Done         <= done_d;
            Frame_Count        <= frame_count_nxt;
        end
    end

    // Select the frame word addressed by the send index.
    always_comb begin
        send_word = FRAME_TRAILER;
        if (send_idx == 4'd0)                send_word = FRAME_HEADER;
        else if (send_idx == 4'd1)           send_word = info_q;
        else if (send_idx <= LAST_DATA_IDX)  send_word = buffer[send_idx[2:0] - 3'd2];
        else if (send_idx == CSUM_IDX)       send_word = checksum;
    end

    // Capture buffer, checksum, info latch and send sequencing.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            send_idx <= '0;
            checksum <= '0;
            info_q   <= '0;
            for (int i = 0; i < MAX_WORDS_PER_CHANNEL; i++) buffer[i] <= '0;
        end else begin
            case (state_q)
                ST_RD_CAPTURE: begin
                    buffer[word_cnt[2:0]] <= bus.Fifo_Dout;
                    checksum              <= checksum ^ bus.Fifo_Dout;
                    if (word_cnt == 4'd0) info_q <= info_word(Channel_Index, Dac_Code);
                    word_cnt              <= word_cnt + 4'd1;
                    send_idx              <= '0;
                end
                ST_SEND: if (!bus.Usb_Fifo_Full) send_idx <= send_idx + 4'd1;
                ST_DONE: begin
                    word_cnt <= '0;
                    checksum <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scurve_frame_reader.sv
// Bench for scurve_frame_reader: FIFO source model, USB sink monitor,
// table-driven frames, randomized frames against a frame model, and
// hand-written enable-drop, reset and counter-wrap sequences.
module tb_scurve_frame_reader;
    import scurve_pkg::*;

    localparam int N = 6;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Packer_Enable = 1'b0;
    logic [5:0]  Channel_Index = '0;
    logic [9:0]  Dac_Code = '0;
    logic        Frame_Done;
    logic [15:0] Frame_Count;
    state_t      Fsm_State;

    always #5 Clk = ~Clk;

    scurve_frame_reader_if bus ();

    scurve_frame_reader #(.WORDS_PER_CHANNEL(N)) dut (
        .Clk           (Clk),
        .reset_n       (reset_n),
        .Packer_Enable (Packer_Enable),
        .Channel_Index (Channel_Index),
        .Dac_Code      (Dac_Code),
        .bus           (bus.master),
        .Frame_Done    (Frame_Done),
        .Frame_Count   (Frame_Count),
        .Fsm_State     (Fsm_State)
    );

    // ---------------- source FIFO model (non-FWFT) ----------------
    logic [15:0] src [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int rd_empty_err = 0;

    assign bus.Fifo_Empty = (rd_ptr >= wr_ptr);

    always @(posedge Clk) begin
        if (bus.Fifo_Rd_En) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_ptr >= wr_ptr) rd_empty_err <= rd_empty_err + 1;
            else begin
                bus.Fifo_Dout <= src[rd_ptr];
                rd_ptr        <= rd_ptr + 1;
            end
        end
    end

    // ---------------- USB sink monitor ----------------
    logic [15:0] usb_log [$];
    int   done_cnt = 0;
    int   stall_err = 0;
    logic full_prev = 1'b0;

    always @(negedge Clk) begin
        if (bus.Usb_Data_Wr_En) begin
            usb_log.push_back(bus.Usb_Data);
            if (full_prev) stall_err++;
        end
        if (Frame_Done) done_cnt++;
        full_prev = bus.Usb_Fifo_Full;
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q [$];
    logic [15:0] exp_frames = '0;
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        src[wr_ptr] = w;
        wr_ptr++;
    endtask

    // Reference frame built from the framing rules.
    function automatic void model_frame(input logic [5:0] ch, input logic [9:0] dac,
                                        input logic [0:5][15:0] data);
        logic [15:0] x;
        x = '0;
        exp_q.push_back(16'hFF45);
        exp_q.push_back({ch, dac});
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(data[i]);
            x = x ^ data[i];
        end
        exp_q.push_back(x);
        exp_q.push_back(16'hFF5A);
    endfunction

    task automatic finish_frame(input string tag, input int log0, input int rd0,
                                input int done0, input int exp_reads);
        int t;
        int idx;
        t = 0;
        while (done_cnt == done0 && t < 1000) begin
            tick(1);
            t++;
        end
        tick(2);
        exp_frames = exp_frames + 16'd1;
        check({tag, " done_pulses"}, done_cnt - done0, 1);
        check({tag, " writes"}, usb_log.size() - log0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            idx = log0 + i;
            check($sformatf("%s word%0d", tag, i),
                  (idx < usb_log.size()) ? {16'h0, usb_log[idx]} : 32'hDEAD_BEEF,
                  {16'h0, exp_q[i]});
        end
        check({tag, " reads"}, rd_cnt - rd0, exp_reads);
        check({tag, " frame_count"}, {16'h0, Frame_Count}, {16'h0, exp_frames});
        exp_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [5:0] ch, input logic [9:0] dac,
                             input logic [0:5][15:0] data, input int gap,
                             input int stall_at, input int stall_len);
        int log0, rd0, done0, t;
        log0 = usb_log.size();
        rd0  = rd_cnt;
        done0 = done_cnt;
        Channel_Index = ch;
        Dac_Code      = dac;
        Packer_Enable = 1'b1;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    tick(gap);
                    push_word(data[i]);
                end
            end
            begin
                if (stall_at > 0) begin
                    t = 0;
                    while (usb_log.size() < log0 + stall_at && t < 1000) begin
                        tick(1);
                        t++;
                    end
                    bus.Usb_Fifo_Full = 1'b1;
                    tick(stall_len);
                    bus.Usb_Fifo_Full = 1'b0;
                end
            end
        join
        finish_frame(tag, log0, rd0, done0, N);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [5:0]        ch;
        logic [9:0]        dac;
        logic [0:5][15:0]  data;
        int                gap;
        int                stall_at;
        int                stall_len;
        logic [15:0]       exp_info;
        logic [15:0]       exp_csum;
    } vec_t;

    vec_t vecs [0:5];

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:5][15:0] rdata;
        logic [5:0]       rch;
        logic [9:0]       rdac;
        int log0, rd0, done0, t;

        vecs[0] = '{ch: 6'd5,    dac: 10'h123, data: {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
                    gap: 0,  stall_at: 0, stall_len: 0, exp_info: 16'h1523, exp_csum: 16'h0007};
        vecs[1] = '{ch: 6'd5,    dac: 10'h123, data: {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
                    gap: 20, stall_at: 0, stall_len: 0, exp_info: 16'h1523, exp_csum: 16'h0007};
        vecs[2] = '{ch: 6'd5,    dac: 10'h123, data: {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
                    gap: 0,  stall_at: 4, stall_len: 5, exp_info: 16'h1523, exp_csum: 16'h0007};
        vecs[3] = '{ch: 6'h3F,   dac: 10'h3FF, data: {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000},
                    gap: 3,  stall_at: 1, stall_len: 2, exp_info: 16'hFFFF, exp_csum: 16'hFFFF};
        vecs[4] = '{ch: 6'd1,    dac: 10'h001, data: {16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400},
                    gap: 1,  stall_at: 9, stall_len: 3, exp_info: 16'h0401, exp_csum: 16'hFC00};
        vecs[5] = '{ch: 6'h20,   dac: 10'h200, data: {16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002},
                    gap: 0,  stall_at: 0, stall_len: 0, exp_info: 16'h8200, exp_csum: 16'h0003};

        // ---- reset state ----
        bus.Usb_Fifo_Full = 1'b0;
        reset_n = 1'b0;
        tick(3);
        check("rst rd_en",   {31'h0, bus.Fifo_Rd_En}, 0);
        check("rst wr_en",   {31'h0, bus.Usb_Data_Wr_En}, 0);
        check("rst usb_data", {16'h0, bus.Usb_Data}, 0);
        check("rst done",    {31'h0, Frame_Done}, 0);
        check("rst count",   {16'h0, Frame_Count}, 0);
        reset_n = 1'b1;
        tick(3);
        check("idle state",  {29'h0, Fsm_State}, {29'h0, ST_IDLE});
        check("idle no_reads", rd_cnt, 0);

        // ---- table-driven frames ----
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(16'hFF45);
            exp_q.push_back(vecs[v].exp_info);
            for (int i = 0; i < N; i++) exp_q.push_back(vecs[v].data[i]);
            exp_q.push_back(vecs[v].exp_csum);
            exp_q.push_back(16'hFF5A);
            run_frame($sformatf("vec%0d", v), vecs[v].ch, vecs[v].dac, vecs[v].data,
                      vecs[v].gap, vecs[v].stall_at, vecs[v].stall_len);
        end

        // ---- randomized frames against the model ----
        for (int r = 0; r < 8; r++) begin
            rch  = 6'($urandom_range(0, 63));
            rdac = 10'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++) rdata[i] = 16'($urandom);
            model_frame(rch, rdac, rdata);
            run_frame($sformatf("rnd%0d", r), rch, rdac, rdata, $urandom_range(0, 4),
                      $urandom_range(0, 9), $urandom_range(1, 6));
        end

        // ---- enable drop after the 3rd capture ----
        rdata = {16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
        model_frame(6'd9, 10'h2AA, rdata);
        log0 = usb_log.size(); rd0 = rd_cnt; done0 = done_cnt;
        Channel_Index = 6'd9;
        Dac_Code      = 10'h2AA;
        Packer_Enable = 1'b1;
        for (int i = 0; i < 3; i++) push_word(rdata[i]);
        t = 0;
        while (rd_cnt < rd0 + 3 && t < 200) begin
            tick(1);
            t++;
        end
        tick(3);
        Packer_Enable = 1'b0;
        Channel_Index = 6'd33;
        Dac_Code      = 10'h055;
        tick(5);
        for (int i = 3; i < N; i++) push_word(rdata[i]);
        finish_frame("endrop", log0, rd0, done0, N);
        check("endrop idle", {29'h0, Fsm_State}, {29'h0, ST_IDLE});

        // ---- enable drop with nothing captured ----
        rd0 = rd_cnt; log0 = usb_log.size();
        Packer_Enable = 1'b1;
        tick(10);
        check("drop0 wait_state", {29'h0, Fsm_State}, {29'h0, ST_RD_WAIT});
        Packer_Enable = 1'b0;
        tick(2);
        check("drop0 idle", {29'h0, Fsm_State}, {29'h0, ST_IDLE});
        push_word(16'h0BAD);
        tick(20);
        check("drop0 no_reads", rd_cnt - rd0, 0);
        check("drop0 no_writes", usb_log.size() - log0, 0);

        // ---- reset during SEND at word 4 (the 0BAD word is this frame's first) ----
        log0 = usb_log.size(); done0 = done_cnt;
        Channel_Index = 6'd2;
        Dac_Code      = 10'h010;
        Packer_Enable = 1'b1;
        for (int i = 0; i < 5; i++) push_word(16'h1111 * 16'(i + 1));
        t = 0;
        while (usb_log.size() < log0 + 4 && t < 500) begin
            tick(1);
            t++;
        end
        check("rstmid reached_send", usb_log.size() - log0, 4);
        reset_n = 1'b0;
        #1;
        check("rstmid wr_en",    {31'h0, bus.Usb_Data_Wr_En}, 0);
        check("rstmid usb_data", {16'h0, bus.Usb_Data}, 0);
        check("rstmid rd_en",    {31'h0, bus.Fifo_Rd_En}, 0);
        check("rstmid done",     {31'h0, Frame_Done}, 0);
        check("rstmid count",    {16'h0, Frame_Count}, 0);
        check("rstmid state",    {29'h0, Fsm_State}, {29'h0, ST_IDLE});
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("rstmid no_done", done_cnt - done0, 0);
        exp_frames = '0;
        exp_q.push_back(16'hFF45);
        exp_q.push_back(vecs[5].exp_info);
        for (int i = 0; i < N; i++) exp_q.push_back(vecs[5].data[i]);
        exp_q.push_back(vecs[5].exp_csum);
        exp_q.push_back(16'hFF5A);
        run_frame("after_rst", vecs[5].ch, vecs[5].dac, vecs[5].data, 0, 0, 0);

        // ---- frame counter wrap ----
        force dut.frame_count_nxt = 16'hFFFF;
        tick(1);
        release dut.frame_count_nxt;
        tick(1);
        check("wrap preset", {16'h0, Frame_Count}, 32'h0000_FFFF);
        exp_frames = 16'hFFFF;
        rdata = {16'h7777, 16'h0000, 16'h1234, 16'h4321, 16'hFFFF, 16'h0F0F};
        model_frame(6'd63, 10'd0, rdata);
        run_frame("wrap", 6'd63, 10'd0, rdata, 2, 0, 0);
        check("wrap zero", {16'h0, Frame_Count}, 0);

        // ---- global protocol checks ----
        check("rd_while_empty", rd_empty_err, 0);
        check("write_while_full", stall_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
